// File: rtl/rv_pkg.sv
// RV32I opcode constants and register-field positions shared by the
// register-read stage logic.
package rv_pkg;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int REG_W   = 5;
  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
endpackage

// File: rtl/rv_reg_use_decode.sv
// Combinational register-usage decode of an RV32I instruction word:
// which of rs1/rs2 are read and whether rd is written.
module rv_reg_use_decode
  import rv_pkg::*;
(
  input  logic [31:0]      ir,
  output logic [REG_W-1:0] rs1,
  output logic [REG_W-1:0] rs2,
  output logic [REG_W-1:0] rd,
  output logic             uses_rs1,
  output logic             uses_rs2,
  output logic             writes_rd
);
  logic [6:0] w_opc;
  logic       w_unused_ir;

  assign w_opc       = ir[OPC_LSB +: 7];
  assign rs1         = ir[RS1_LSB +: REG_W];
  assign rs2         = ir[RS2_LSB +: REG_W];
  assign rd          = ir[RD_LSB +: REG_W];
  assign w_unused_ir = ^{ir[31:25], ir[14:12]};

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    case (w_opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL: writes_rd = 1'b1;
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_BRANCH, OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_OP: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/read_scoreboard.sv
// Register-read issue scoreboard: pending-write tracking, RAW/WAW/inflight
// hazard gating, stall counting and write-back checking. Macro: SB_WB_BYPASS_EN.
module read_scoreboard
  import rv_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [31:0]      issue_IR,
  input  logic             wb_valid,
  input  logic [4:0]       wb_address,
  input  logic             flush,
  output logic             issue_ready,
  output logic [31:0]      pending,
  output logic [3:0]       inflight,
  output logic [CNT_W-1:0] stall_count,
  output logic             sb_err
);
  localparam logic [3:0] MAX_INF = 4'(MAX_INFLIGHT);

  logic [31:0]      r_pending;
  logic [31:0]      r_flush_seen;
  logic [3:0]       r_inflight;
  logic [CNT_W-1:0] r_stall;
  logic             r_err;

  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic        w_dec_rs1, w_dec_rs2, w_dec_rd;
  logic        w_use_rs1, w_use_rs2, w_wr_rd;
  logic        w_wb_live, w_wb_hit, w_wb_err;
  logic [31:0] w_clr_mask, w_set_mask, w_haz_pending;
  logic [3:0]  w_haz_inflight;
  logic        w_hazard, w_accept_set;

  rv_reg_use_decode u_decode (
    .ir        (issue_IR),
    .rs1       (w_rs1),
    .rs2       (w_rs2),
    .rd        (w_rd),
    .uses_rs1  (w_dec_rs1),
    .uses_rs2  (w_dec_rs2),
    .writes_rd (w_dec_rd)
  );

  // x0 is never a dependency and never becomes pending.
  assign w_use_rs1 = w_dec_rs1 & (w_rs1 != 5'd0);
  assign w_use_rs2 = w_dec_rs2 & (w_rs2 != 5'd0);
  assign w_wr_rd   = w_dec_rd  & (w_rd  != 5'd0);

  assign w_wb_live  = wb_valid & (wb_address != 5'd0);
  assign w_wb_hit   = w_wb_live & r_pending[wb_address];
  assign w_wb_err   = w_wb_live & ~r_pending[wb_address] & ~r_flush_seen[wb_address];
  assign w_clr_mask = w_wb_hit ? (32'd1 << wb_address) : 32'd0;

`ifdef SB_WB_BYPASS_EN
  assign w_haz_pending  = r_pending & ~w_clr_mask;
  assign w_haz_inflight = r_inflight - 4'(w_wb_hit);
`else
  assign w_haz_pending  = r_pending;
  assign w_haz_inflight = r_inflight;
`endif

  assign w_hazard = (w_use_rs1 & w_haz_pending[w_rs1])
                  | (w_use_rs2 & w_haz_pending[w_rs2])
                  | (w_wr_rd & w_haz_pending[w_rd])
                  | (w_wr_rd & (w_haz_inflight >= MAX_INF));

  assign issue_ready  = rst_n & issue_valid & ~w_hazard & ~flush;
  assign w_accept_set = issue_ready & w_wr_rd;
  assign w_set_mask   = w_accept_set ? (32'd1 << w_rd) : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending    <= '0;
      r_flush_seen <= '0;
      r_inflight   <= '0;
      r_stall      <= '0;
      r_err        <= 1'b0;
    end else begin
      if (flush) begin
        // Registers dropped here may still see a late write-back; don't flag it.
        r_pending    <= '0;
        r_inflight   <= '0;
        r_flush_seen <= r_flush_seen | (r_pending & ~w_clr_mask);
      end else begin
        r_pending    <= (r_pending & ~w_clr_mask) | w_set_mask;
        r_inflight   <= r_inflight + 4'(w_accept_set) - 4'(w_wb_hit);
        r_flush_seen <= r_flush_seen & ~w_set_mask;
      end
      if (w_wb_err) r_err <= 1'b1;
      if (issue_valid & ~issue_ready & ~(&r_stall)) r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign pending     = r_pending;
  assign inflight    = r_inflight;
  assign stall_count = r_stall;
  assign sb_err      = r_err;
endmodule

// File: tb/tb_read_scoreboard.sv
// Scoreboard bench for read_scoreboard: directed scenarios plus random traffic,
// each cycle's expectation queued by the driver and checked by a monitor.
module tb_read_scoreboard;
  localparam int MAXI = 4;
  localparam int CW   = 4;
  localparam int SAT  = (1 << CW) - 1;
`ifdef SB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_valid = 1'b0;
  logic [31:0]   issue_IR = '0;
  logic          wb_valid = 1'b0;
  logic [4:0]    wb_address = '0;
  logic          flush = 1'b0;
  logic          issue_ready;
  logic [31:0]   pending;
  logic [3:0]    inflight;
  logic [CW-1:0] stall_count;
  logic          sb_err;

  read_scoreboard #(.MAX_INFLIGHT(MAXI), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_IR    (issue_IR),
    .wb_valid    (wb_valid),
    .wb_address  (wb_address),
    .flush       (flush),
    .issue_ready (issue_ready),
    .pending     (pending),
    .inflight    (inflight),
    .stall_count (stall_count),
    .sb_err      (sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        rdy;
    bit [31:0] pend;
    int        infl;
    int        stall;
    bit        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: set of registers with an outstanding write.
  int m_out[$];
  bit m_flushed[32];
  bit m_err;
  int m_stall;

  logic [6:0] opcs[10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                           7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1111111};

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void reg_use(input logic [31:0] ir, output bit r1, output bit r2, output bit w);
    r1 = 0; r2 = 0; w = 0;
    case (ir[6:0])
      7'b0110111, 7'b0010111, 7'b1101111: w = 1;
      7'b1100111, 7'b0000011, 7'b0010011: begin r1 = 1; w = 1; end
      7'b1100011, 7'b0100011:             begin r1 = 1; r2 = 1; end
      7'b0110011:                         begin r1 = 1; r2 = 1; w = 1; end
      default: ;
    endcase
  endfunction

  function automatic bit model_step(input bit rst, input bit iv, input logic [31:0] ir,
                                    input bit wbv, input logic [4:0] wba, input bit fl);
    exp_t e;
    bit   blk[32];
    bit   r1, r2, w, hit, haz, rdy;
    int   rs1, rs2, rd, cnt, idx;
    e = '{rdy: 0, pend: 0, infl: 0, stall: 0, err: 0};
    if (!rst) begin
      m_out.delete();
      m_flushed = '{default: 0};
      m_err = 0;
      m_stall = 0;
      exp_q.push_back(e);
      return 0;
    end
    blk = '{default: 0};
    foreach (m_out[i]) begin
      e.pend[m_out[i]] = 1'b1;
      blk[m_out[i]] = 1'b1;
    end
    e.infl  = m_out.size();
    e.stall = m_stall;
    e.err   = m_err;
    hit = wbv && (wba != 0) && blk[wba];
    cnt = m_out.size();
    if (BYP && hit) begin
      blk[wba] = 1'b0;
      cnt = cnt - 1;
    end
    reg_use(ir, r1, r2, w);
    rs1 = ir[19:15]; rs2 = ir[24:20]; rd = ir[11:7];
    haz = (r1 && rs1 != 0 && blk[rs1]) || (r2 && rs2 != 0 && blk[rs2]) ||
          (w && rd != 0 && (blk[rd] || cnt >= MAXI));
    rdy = iv && !haz && !fl;
    e.rdy = rdy;
    exp_q.push_back(e);
    if (hit) begin
      idx = 0;
      foreach (m_out[i]) if (m_out[i] == int'(wba)) idx = i;
      m_out.delete(idx);
    end else if (wbv && wba != 0 && !m_flushed[wba]) begin
      m_err = 1;
    end
    if (rdy && w && rd != 0) begin
      m_out.push_back(rd);
      m_flushed[rd] = 0;
    end
    if (fl) begin
      foreach (m_out[i]) m_flushed[m_out[i]] = 1;
      m_out.delete();
    end
    if (iv && !rdy && m_stall < SAT) m_stall++;
    return rdy;
  endfunction

  task automatic cycle(input bit rst, input bit iv, input logic [31:0] ir,
                       input bit wbv, input logic [4:0] wba, input bit fl, output bit rdy);
    @(posedge clk);
    #1;
    rst_n = rst; issue_valid = iv; issue_IR = ir;
    wb_valid = wbv; wb_address = wba; flush = fl;
    rdy = model_step(rst, iv, ir, wbv, wba, fl);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("mon_ready",    issue_ready, e.rdy);
      chk("mon_pending",  pending,     e.pend);
      chk("mon_inflight", inflight,    e.infl);
      chk("mon_stall",    stall_count, e.stall);
      chk("mon_sb_err",   sb_err,      e.err);
      chk("mon_infl_max", (inflight <= MAXI), 1);
    end
  end

  function automatic logic [31:0] enc(input logic [6:0] opc, input int rd, input int rs1, input int rs2);
    logic [31:0] v;
    v = '0;
    v[6:0] = opc; v[11:7] = 5'(rd); v[19:15] = 5'(rs1); v[24:20] = 5'(rs2);
    return v;
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [31:0] v;
    v = $urandom;
    v[6:0]   = opcs[$urandom_range(0, 9)];
    v[11:7]  = 5'($urandom_range(0, 7));
    v[19:15] = 5'($urandom_range(0, 7));
    v[24:20] = 5'($urandom_range(0, 7));
    return v;
  endfunction

  task automatic do_reset();
    bit r;
    cycle(0, 0, '0, 0, 0, 0, r);
    cycle(0, 0, '0, 0, 0, 0, r);
  endtask

  task automatic idle();
    bit r;
    cycle(1, 0, '0, 0, 0, 0, r);
    #2;
  endtask

  initial begin
    bit          r, have, wbv, fl, rst;
    logic [4:0]  wba;
    logic [31:0] cur_ir;

    do_reset();
    chk("reset_pending", pending, 0);
    chk("reset_ready", issue_ready, 0);

    // ADD x3,x1,x2 right after release, then dependent ADD x4,x3,x1.
    cycle(1, 1, enc(7'b0110011, 3, 1, 2), 0, 0, 0, r); #2;
    chk("add_ready", issue_ready, 1);
    idle();
    chk("add_pending", pending, 32'h8);
    chk("add_inflight", inflight, 1);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 1, enc(7'b0110011, 4, 3, 1), 0, 0, 0, r); #2;
      chk("raw_stall", issue_ready, 0);
    end
    cycle(1, 1, enc(7'b0110011, 4, 3, 1), 1, 3, 0, r); #2;
    chk("raw_wb_cycle", issue_ready, BYP);
    if (!BYP) begin
      cycle(1, 1, enc(7'b0110011, 4, 3, 1), 0, 0, 0, r); #2;
      chk("raw_after_wb", issue_ready, 1);
    end
    idle();
    chk("raw_stall_cnt", stall_count, BYP ? 3 : 4);
    chk("raw_pending", pending, 32'h10);

    // Stall counter saturation.
    for (int k = 0; k < 16; k++) cycle(1, 1, enc(7'b0110011, 6, 4, 0), 0, 0, 0, r);
    idle();
    chk("stall_sat", stall_count, SAT);
    cycle(1, 1, enc(7'b0110011, 6, 4, 0), 1, 4, 0, r);
    if (!r) cycle(1, 1, enc(7'b0110011, 6, 4, 0), 0, 0, 0, r);
    idle();
    chk("stall_sat_hold", stall_count, SAT);

    // Inflight limit with five independent OP-IMM writes.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(1, 1, enc(7'b0010011, 5 + k, 0, 0), 0, 0, 0, r); #2;
      chk("lim_accept", issue_ready, 1);
    end
    cycle(1, 1, enc(7'b0010011, 9, 0, 0), 0, 0, 0, r); #2;
    chk("lim_full_ready", issue_ready, 0);
    chk("lim_full_infl", inflight, 4);
    cycle(1, 1, enc(7'b0010011, 9, 0, 0), 1, 5, 0, r); #2;
    chk("lim_wb_cycle", issue_ready, BYP);
    if (!BYP) begin
      cycle(1, 1, enc(7'b0010011, 9, 0, 0), 0, 0, 0, r); #2;
      chk("lim_after_wb", issue_ready, 1);
    end
    cycle(1, 1, enc(7'b0100011, 0, 0, 0), 1, 0, 0, r); #2;
    chk("store_x0_ready", issue_ready, 1);
    cycle(1, 1, enc(7'b0110111, 0, 0, 0), 0, 0, 0, r); #2;
    chk("lui_x0_ready", issue_ready, 1);
    idle();
    chk("lim_pending", pending, 32'h3C0);
    chk("lim_inflight", inflight, 4);
    chk("wb_x0_no_err", sb_err, 0);

    // Flush with two writes outstanding, late write-backs.
    do_reset();
    cycle(1, 1, enc(7'b0110011, 3, 1, 2), 0, 0, 0, r);
    cycle(1, 1, enc(7'b0110011, 4, 1, 2), 0, 0, 0, r);
    cycle(1, 1, enc(7'b0110011, 5, 0, 0), 0, 0, 1, r); #2;
    chk("flush_ready", issue_ready, 0);
    cycle(1, 1, enc(7'b0110011, 5, 0, 0), 0, 0, 0, r); #2;
    chk("flush_pending", pending, 0);
    chk("flush_inflight", inflight, 0);
    cycle(1, 0, '0, 1, 3, 0, r);
    cycle(1, 0, '0, 1, 4, 0, r);
    idle();
    chk("flush_late_wb", sb_err, 0);
    chk("flush_then_pend", pending, 32'h20);
    cycle(1, 0, '0, 1, 12, 0, r);
    idle();
    chk("wb_nonpend_err", sb_err, 1);
    cycle(1, 0, '0, 1, 0, 0, r);
    idle();
    chk("err_sticky", sb_err, 1);

    // Asynchronous reset mid-stream.
    cycle(1, 1, enc(7'b0110011, 7, 0, 0), 0, 0, 0, r);
    cycle(0, 1, enc(7'b0110011, 8, 0, 0), 0, 0, 0, r); #2;
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_infl", inflight, 0);
    chk("mid_rst_err", sb_err, 0);
    chk("mid_rst_ready", issue_ready, 0);
    cycle(0, 1, enc(7'b0110011, 8, 0, 0), 0, 0, 0, r);
    cycle(1, 1, enc(7'b0110011, 8, 0, 0), 1, 7, 0, r); #2;
    chk("post_rst_ready", issue_ready, 1);
    idle();
    chk("post_rst_wb_err", sb_err, 1);

    // Random traffic with occasional flushes and resets.
    do_reset();
    have = 0;
    cur_ir = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!have && $urandom_range(0, 9) < 7) begin
        cur_ir = rand_ir();
        have = 1;
      end
      wbv = 0; wba = '0;
      if ($urandom_range(0, 9) < 4) begin
        wbv = 1;
        if (m_out.size() > 0 && $urandom_range(0, 9) < 8)
          wba = 5'(m_out[$urandom_range(0, m_out.size() - 1)]);
        else
          wba = 5'($urandom_range(0, 7));
      end
      fl  = ($urandom_range(0, 49) == 0);
      rst = !((i % 500) == 499);
      cycle(rst, have, cur_ir, wbv, wba, fl, r);
      if (r) have = 0;
    end
    idle();
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/read_scoreboard.md
# read_scoreboard

Issue-control scoreboard for the register-read stage. It tracks which architectural registers have a write-back outstanding and decides each cycle whether the instruction presented to the read stage may be accepted. The read stage latches IR/PC and reads operands A and B only when this block asserts `issue_ready`. It also counts stall cycles and flags inconsistent write-backs.

## Interface
- `MAX_INFLIGHT`, default 4: maximum outstanding register-writing instructions (1..15).
- `CNT_W`, default 16: width of the stall-cycle counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; one clock, reset asynchronous and active-low.
- `issue_valid`  in  1  an instruction is presented to the read stage.
- `issue_IR`  in  32  the presented RV32I instruction word.
- `wb_valid`  in  1  write-back to the register file this cycle.
- `wb_address`  in  5  write-back destination register.
- `flush`  in  1  pipeline flush: discard all pending state.
- `issue_ready`  out  1  presented instruction accepted this cycle (combinational).
- `pending`  out  32  per-register outstanding-write mask; bit 0 always 0.
- `inflight`  out  4  count of outstanding register writes.
- `stall_count`  out  CNT_W  saturating count of cycles with `issue_valid & !issue_ready`.
- `sb_err`  out  1  sticky: write-back to a non-pending register other than x0.

## Operation
- Decode from `issue_IR[6:0]`:
  - writes rd: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.
  - reads rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - reads rs2: BRANCH, STORE, OP.
  - Unknown opcodes read and write nothing.
  - rs1/rd/rs2 fields are `[19:15]`, `[11:7]`, `[24:20]`. Any use of x0 is ignored.
- Hazard: a used rs1 or rs2 is pending (RAW), or the used rd is pending (WAW), or the instruction writes rd and `inflight == MAX_INFLIGHT`.
- `issue_ready = rst_n & issue_valid & !hazard & !flush`.
- Accept: set `pending[rd]` if rd is written and nonzero; increment `inflight`.
- Write-back with `wb_address != 0`:
  - If `pending[wb_address]` is set: clear it and decrement `inflight`.
  - Otherwise: set `sb_err`; pending and inflight are unchanged.
- Write-back to x0 is ignored.
- Same cycle, accept rd = X and write-back X: set wins; `pending[X]` stays 1; `inflight` is unchanged.
- Flush: `pending` and `inflight` are cleared at the next edge. No accept occurs that cycle. Later write-backs to cleared registers are ignored without setting `sb_err`. A `flush_seen` mask suppresses the error per register until that register is set again.
- `stall_count` holds at its all-ones value (saturates). It is cleared only by reset.

## Timing
- Reset values:
  - `pending` = 0, `inflight` = 0, `stall_count` = 0, `sb_err` = 0.
  - `issue_ready` = 0 while `rst_n` is low; it is 1 for a hazard-free instruction on the first edge after release.
- `issue_ready` is combinational, with zero-cycle latency from `issue_IR`, `issue_valid` and state.
- Scoreboard updates at the edge where accept or write-back occurs. Effects are visible from the next cycle.
- A dependent instruction presented the cycle after its producer issues stalls until that producer's write-back cycle. Acceptance timing then depends on the macro below.
- An instruction held with `issue_valid` high must keep `issue_IR` stable until accepted.
- Reset asserted mid-operation clears all state immediately; outstanding write-backs after release set `sb_err`.

## Configuration
- `SB_WB_BYPASS_EN`:
  - Defined: a write-back in the current cycle resolves hazards on `wb_address` in that same cycle, for both RAW/WAW and the inflight limit. The register file is write-through.
  - Undefined: write-backs resolve hazards only from the following cycle, adding one stall cycle per dependency.

## Structure
- Shared package `rv_pkg`: 7-bit opcode constants (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP) and register-field bit positions.
- Sub-module `rv_reg_use_decode`: purely combinational. IR in; rs1, rs2, rd and the use flags `uses_rs1`, `uses_rs2`, `writes_rd` out.

## Test plan
- Reset, then ADD x3,x1,x2 valid, no write-backs -> accepted cycle 1; `pending` = 0x00000008; `inflight` = 1.
- ADD x3 accepted, then ADD x4,x3,x1 held -> `issue_ready` = 0 until `wb_address` = 3. Accepted in the write-back cycle with the macro defined, the cycle after without it. `stall_count` equals the number of stall cycles.
- Five independent OP-IMM writes (x5..x9) back-to-back, `MAX_INFLIGHT` = 4 -> four accepted; fifth stalls until any write-back; `inflight` never exceeds 4.
- Write-back to x12 with nothing pending -> `sb_err` = 1 and stays 1. Write-back to x0 -> no change.
- STORE using x0/x0 and LUI to x0 -> always accepted; `pending` stays 0.
- Two writes outstanding, then `flush` pulse -> `pending` = 0 and `inflight` = 0 next cycle. Late write-backs leave `sb_err` = 0. `rst_n` low mid-stream -> all outputs return to reset values immediately.
